// File: rtl/aes_round_ctrl.sv
// Round/slice sequencer for the AES core: AES-128/192/256, optional decrypt
// key-schedule pre-pass, SLICE_W-bit datapath slices, start/busy/done handshake.
module aes_round_ctrl #(
  parameter  int SLICE_W = 32,
  localparam int SLICES  = 128 / SLICE_W,
  localparam int SW      = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          enc_dec,
  input  logic [1:0]    mode,
  input  logic          abort,
  output logic          busy,
  output logic          enc_dec_q,
  output logic [1:0]    mode_q,
  output logic          key_gen,
  output logic [3:0]    key_gen_round,
  output logic          slice_valid,
  output logic [3:0]    round,
  output logic [3:0]    key_idx,
  output logic [SW-1:0] slice_sel,
  output logic          round_start,
  output logic          round_last,
  output logic          final_round,
  output logic          done,
  output logic          error,
  output logic [1:0]    state_dbg
);

  // Handshake: start is a level request sampled only in IDLE; busy is high
  // from the cycle after acceptance through the single done cycle; abort is
  // honoured in any non-IDLE state and wins over every other transition.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYGEN = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [SW-1:0] slice_sel_q, slice_sel_d;
  logic [3:0]    kg_round_q, kg_round_d;
  logic [1:0]    mode_d;
  logic          enc_dec_d;
  logic          error_q, error_d;
  logic [3:0]    nr;
  logic          slice_last;

  // Nr follows the captured mode only, never the live input.
  always_comb begin
    case (mode_q)
      2'd1:    nr = 4'd12;
      2'd2:    nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  assign slice_last = (slice_sel_q == LAST_SLICE);

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    slice_sel_d = slice_sel_q;
    kg_round_d  = kg_round_q;
    mode_d      = mode_q;
    enc_dec_d   = enc_dec_q;
    error_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode == 2'b11) begin
            error_d = 1'b1;
          end else begin
            mode_d      = mode;
            enc_dec_d   = enc_dec;
            state_d     = enc_dec ? KEYGEN : RUN;
            round_d     = 4'd0;
            slice_sel_d = '0;
            kg_round_d  = 4'd0;
          end
        end
      end
      KEYGEN: begin
        if (kg_round_q == nr) begin
          state_d     = RUN;
          round_d     = 4'd0;
          slice_sel_d = '0;
          kg_round_d  = 4'd0;
        end else begin
          kg_round_d = kg_round_q + 4'd1;
        end
      end
      RUN: begin
        if (slice_last) begin
          slice_sel_d = '0;
          if (round_q == nr) begin
            state_d = DONE;
            round_d = 4'd0;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          slice_sel_d = slice_sel_q + SW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      round_d     = 4'd0;
      slice_sel_d = '0;
      kg_round_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      slice_sel_q <= '0;
      kg_round_q  <= 4'd0;
      mode_q      <= 2'd0;
      enc_dec_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      slice_sel_q <= slice_sel_d;
      kg_round_q  <= kg_round_d;
      mode_q      <= mode_d;
      enc_dec_q   <= enc_dec_d;
      error_q     <= error_d;
    end
  end

  // Outputs decode registered state and counters only.
  assign busy          = (state_q != IDLE);
  assign key_gen       = (state_q == KEYGEN);
  assign key_gen_round = kg_round_q;
  assign slice_valid   = (state_q == RUN);
  assign round         = round_q;
  assign key_idx       = enc_dec_q ? (nr - round_q) : round_q;
  assign slice_sel     = slice_sel_q;
  assign round_start   = slice_valid && (slice_sel_q == '0);
  assign round_last    = slice_valid && slice_last;
  assign final_round   = slice_valid && (round_q == nr);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: three instances (SLICE_W 32/128/8), per-cycle
// expected output records queued at start acceptance and compared each cycle.
module tb_aes_round_ctrl;

  localparam int W = 27;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enc_dec = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  int         sel = 0;

  logic s0, s1, s2;
  assign s0 = start && (sel == 0);
  assign s1 = start && (sel == 1);
  assign s2 = start && (sel == 2);

  always #5 clk = ~clk;

  logic       d0_busy, d0_edq, d0_kg, d0_sv, d0_rs, d0_rl, d0_fr, d0_done, d0_err;
  logic [1:0] d0_mq, d0_st;
  logic [3:0] d0_kgr, d0_rnd, d0_kidx;
  logic [1:0] d0_sel;
  logic       d1_busy, d1_edq, d1_kg, d1_sv, d1_rs, d1_rl, d1_fr, d1_done, d1_err;
  logic [1:0] d1_mq, d1_st;
  logic [3:0] d1_kgr, d1_rnd, d1_kidx;
  logic [0:0] d1_sel;
  logic       d2_busy, d2_edq, d2_kg, d2_sv, d2_rs, d2_rl, d2_fr, d2_done, d2_err;
  logic [1:0] d2_mq, d2_st;
  logic [3:0] d2_kgr, d2_rnd, d2_kidx;
  logic [3:0] d2_sel;

  aes_round_ctrl #(.SLICE_W(32)) dut0 (
    .clk(clk), .reset(reset), .start(s0), .enc_dec(enc_dec), .mode(mode), .abort(abort),
    .busy(d0_busy), .enc_dec_q(d0_edq), .mode_q(d0_mq), .key_gen(d0_kg),
    .key_gen_round(d0_kgr), .slice_valid(d0_sv), .round(d0_rnd), .key_idx(d0_kidx),
    .slice_sel(d0_sel), .round_start(d0_rs), .round_last(d0_rl), .final_round(d0_fr),
    .done(d0_done), .error(d0_err), .state_dbg(d0_st));

  aes_round_ctrl #(.SLICE_W(128)) dut1 (
    .clk(clk), .reset(reset), .start(s1), .enc_dec(enc_dec), .mode(mode), .abort(abort),
    .busy(d1_busy), .enc_dec_q(d1_edq), .mode_q(d1_mq), .key_gen(d1_kg),
    .key_gen_round(d1_kgr), .slice_valid(d1_sv), .round(d1_rnd), .key_idx(d1_kidx),
    .slice_sel(d1_sel), .round_start(d1_rs), .round_last(d1_rl), .final_round(d1_fr),
    .done(d1_done), .error(d1_err), .state_dbg(d1_st));

  aes_round_ctrl #(.SLICE_W(8)) dut2 (
    .clk(clk), .reset(reset), .start(s2), .enc_dec(enc_dec), .mode(mode), .abort(abort),
    .busy(d2_busy), .enc_dec_q(d2_edq), .mode_q(d2_mq), .key_gen(d2_kg),
    .key_gen_round(d2_kgr), .slice_valid(d2_sv), .round(d2_rnd), .key_idx(d2_kidx),
    .slice_sel(d2_sel), .round_start(d2_rs), .round_last(d2_rl), .final_round(d2_fr),
    .done(d2_done), .error(d2_err), .state_dbg(d2_st));

  // Record: [26:24] {enc_dec_q,mode_q} [23:20] key_gen_round [19:16] round
  // [15:12] key_idx [11:8] slice_sel [7:0] {busy,key_gen,slice_valid,
  // round_start,round_last,final_round,done,error}
  logic [W-1:0] obs0, obs1, obs2, obs_mux;
  assign obs0 = {d0_edq, d0_mq, d0_kgr, d0_rnd, d0_kidx, 2'b00, d0_sel,
                 d0_busy, d0_kg, d0_sv, d0_rs, d0_rl, d0_fr, d0_done, d0_err};
  assign obs1 = {d1_edq, d1_mq, d1_kgr, d1_rnd, d1_kidx, 3'b000, d1_sel,
                 d1_busy, d1_kg, d1_sv, d1_rs, d1_rl, d1_fr, d1_done, d1_err};
  assign obs2 = {d2_edq, d2_mq, d2_kgr, d2_rnd, d2_kidx, d2_sel,
                 d2_busy, d2_kg, d2_sv, d2_rs, d2_rl, d2_fr, d2_done, d2_err};

  always_comb begin
    case (sel)
      1:       obs_mux = obs1;
      2:       obs_mux = obs2;
      default: obs_mux = obs0;
    endcase
  end

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rec(input logic [2:0] cap, input logic [3:0] kgr,
                                       input logic [3:0] rnd, input logic [3:0] kidx,
                                       input logic [3:0] ss, input logic [7:0] flags);
    return {cap, kgr, rnd, kidx, ss, flags};
  endfunction

  // Scoreboard: one record per cycle; counters only where they are defined.
  logic [W-1:0] mon_e, mon_o;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_o = obs_mux;
      check("flags", 32'(mon_o[7:0]), 32'(mon_e[7:0]));
      if (mon_e[7]) check("capture", 32'(mon_o[26:24]), 32'(mon_e[26:24]));
      if (mon_e[6]) check("key_gen_round", 32'(mon_o[23:20]), 32'(mon_e[23:20]));
      if (mon_e[6] || mon_e[5]) check("round_key_slice", 32'(mon_o[19:8]), 32'(mon_e[19:8]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  function automatic int slices_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 16 : 4);
  endfunction

  task automatic push_op(input int slices, input logic [1:0] m, input logic dec,
                         output int busy_len);
    int nr;
    logic [2:0] cap;
    logic [7:0] fl;
    nr  = 10 + 2 * int'(m);
    cap = {dec, m};
    if (dec) begin
      for (int k = 0; k <= nr; k++)
        exp_q.push_back(rec(cap, 4'(k), 4'd0, 4'(nr), 4'd0, 8'b1100_0000));
    end
    for (int r = 0; r <= nr; r++) begin
      for (int s = 0; s < slices; s++) begin
        fl = {1'b1, 1'b0, 1'b1, (s == 0), (s == slices - 1), (r == nr), 2'b00};
        exp_q.push_back(rec(cap, 4'd0, 4'(r), dec ? 4'(nr - r) : 4'(r), 4'(s), fl));
      end
    end
    exp_q.push_back(rec(cap, 4'd0, 4'd0, 4'd0, 4'd0, 8'b1000_0010));
    push_idle(2);
    busy_len = (dec ? nr + 1 : 0) + (nr + 1) * slices + 1;
  endtask

  task automatic wait_empty();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      tick();
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // Drives start for one cycle; returns positioned at the start of cycle T+1.
  task automatic start_op(input int d, input logic [1:0] m, input logic dec);
    int len;
    wait_empty();
    sel = d;
    mode = m;
    enc_dec = dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    enc_dec = 1'($urandom_range(0, 1));
    if (m == 2'b11) begin
      exp_q.push_back(rec(3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 8'b0000_0001));
      push_idle(2);
    end else begin
      push_op(slices_of(d), m, dec, len);
    end
  endtask

  task automatic check_reset();
    @(negedge clk);
    check("reset_dut0", 32'(obs0), 32'd0);
    check("reset_dut1", 32'(obs1), 32'd0);
    check("reset_dut2", 32'(obs2), 32'd0);
    check("reset_state", 32'({d0_st, d1_st, d2_st}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int d;
    logic [1:0] m;
    logic dec;

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset();
    tick();

    start_op(0, 2'd0, 1'b0);          // AES-128 encrypt, 4 slices
    start_op(0, 2'd2, 1'b1);          // AES-256 decrypt, key-schedule pre-pass
    start_op(1, 2'd1, 1'b0);          // AES-192 encrypt, single slice
    start_op(2, 2'd1, 1'b0);          // AES-192 encrypt, 16 slices
    start_op(0, 2'd3, 1'b0);          // illegal mode
    start_op(1, 2'd0, 1'b1);
    start_op(2, 2'd2, 1'b1);

    // Abort in round 5 slice 1, then restart with abort high while IDLE.
    start_op(0, 2'd0, 1'b0);
    repeat (21) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    push_idle(2);
    wait_empty();
    sel = 0;
    mode = 2'd2;
    enc_dec = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    push_op(4, 2'd2, 1'b1, len);

    // start held through DONE with mode/enc_dec toggling: exactly one op.
    wait_empty();
    sel = 0;
    mode = 2'd1;
    enc_dec = 1'b0;
    start = 1'b1;
    tick();
    push_op(4, 2'd1, 1'b0, len);
    repeat (len) begin
      mode = 2'($urandom_range(0, 3));
      enc_dec = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    // Reset during KEYGEN.
    start_op(0, 2'd1, 1'b1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    push_idle(2);
    check_reset();

    repeat (4) begin
      d   = $urandom_range(0, 2);
      m   = 2'($urandom_range(0, 2));
      dec = 1'($urandom_range(0, 1));
      start_op(d, m, dec);
    end

    wait_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Parametrised round/slice sequencer for the AES core. It supports AES-128/192/256 with a runtime mode select, and drives a datapath that processes SLICE_W bits of the 128-bit state per cycle. For decryption it runs a key-schedule pre-pass, and it exposes a start/busy/done handshake with abort and illegal-mode reporting. It sits between the host-side register interface and the round datapath/key-expansion units, and is the successor to the fixed-width AES FSM.

## Interface
- SLICE_W, 32, datapath slice width in bits; legal values 8, 16, 32, 64, 128.
- SLICES, 128/SLICE_W, derived; not overridden.
- SW, max(1, $clog2(SLICES)), derived width of slice_sel.

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  request; sampled only in IDLE
- enc_dec  in  1  0 = encrypt, 1 = decrypt; captured on accepted start
- mode  in  2  00 = AES-128 (Nr=10), 01 = AES-192 (Nr=12), 10 = AES-256 (Nr=14), 11 = illegal; captured on accepted start
- abort  in  1  cancel the operation in progress
- busy  out  1  high in every state except IDLE
- enc_dec_q  out  1  captured direction
- mode_q  out  2  captured mode
- key_gen  out  1  high during KEYGEN
- key_gen_round  out  4  round-key index being generated, 0..Nr
- slice_valid  out  1  high during RUN
- round  out  4  current round, 0..Nr
- key_idx  out  4  round key to apply: round if encrypting, Nr-round if decrypting
- slice_sel  out  SW  slice index within the round, 0..SLICES-1
- round_start  out  1  high in RUN when slice_sel==0
- round_last  out  1  high in RUN when slice_sel==SLICES-1
- final_round  out  1  high in RUN when round==Nr (datapath skips MixColumns)
- done  out  1  one-cycle pulse on normal completion
- error  out  1  one-cycle pulse on start with mode==11

## Operation
- States: IDLE, KEYGEN, RUN, DONE. Encoding is free.
- IDLE:
  - start=1, mode!=11: capture mode and enc_dec. Go to KEYGEN if decrypting, otherwise RUN. Clear round, slice_sel and key_gen_round to 0.
  - start=1, mode==11: stay in IDLE; error=1 in the following cycle.
- KEYGEN: key_gen=1. key_gen_round increments by 1 each cycle from 0. In the cycle where key_gen_round==Nr, the next state is RUN with round=0 and slice_sel=0.
- RUN: slice_valid=1. slice_sel increments each cycle and wraps from SLICES-1 to 0; round increments on each wrap.
  - When SLICES==1, slice_sel is held at 0 and round_start and round_last are both high every RUN cycle.
  - At round==Nr and slice_sel==SLICES-1, the next state is DONE.
- Round 0 is the initial AddRoundKey; rounds 1..Nr-1 are full rounds; round Nr is the final round.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Nr is derived from mode_q only. Changes on mode, enc_dec or start after acceptance have no effect until the next IDLE.
- abort=1 in KEYGEN, RUN or DONE: next state is IDLE, counters clear, no done pulse. abort takes priority over every transition. abort in IDLE is ignored.
- start while busy is ignored; it is not queued.
- All outputs are driven from flops or decoded solely from the registered state and counters. There is no combinational path from any input to any output.

## Timing
- Reset: state IDLE. busy, key_gen, slice_valid, round_start, round_last, final_round, done, error, enc_dec_q = 0. round, key_idx, slice_sel, key_gen_round, mode_q = 0.
- Let start be accepted at the edge ending cycle T:
  - Encrypt: RUN occupies T+1 .. T+(Nr+1)·SLICES; DONE is at T+(Nr+1)·SLICES+1.
  - Decrypt: KEYGEN occupies T+1 .. T+Nr+1; RUN follows; DONE is at T+Nr+1+(Nr+1)·SLICES+1.
- Back-to-back: a start asserted during the DONE cycle is not accepted. The earliest acceptance is the first IDLE cycle after DONE.
- Abort asserted in cycle A: busy=0 in cycle A+1.
- Reset asserted mid-operation: reset values apply in the next cycle; no done or error pulse.

## Test plan
- AES-128 encrypt, SLICE_W=32, start in T → RUN 44 cycles, round 0→10, key_idx == round, final_round high only during round 10, done at T+45, busy low at T+46.
- AES-256 decrypt, SLICE_W=32 → key_gen_round 0..14 over 15 cycles, then 60 RUN cycles, key_idx 14→0, done at T+76.
- AES-192 encrypt, SLICE_W=128 → 13 RUN cycles with round_start=round_last=1 every cycle, done at T+14. Repeat with SLICE_W=8 → 208 RUN cycles, slice_sel wraps 15→0.
- start with mode=11 → error pulse at T+1, busy stays 0, no done.
- abort during round 5 of AES-128 encrypt → busy=0 the next cycle, no done. A new start is then accepted and completes with correct latency.
- start held high and mode toggled during the operation → exactly one done, Nr unchanged. Reset asserted in KEYGEN → all outputs return to their reset values one cycle later.
